// File: rtl/sequenciador_ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA issue-side sequencer:
//   - 5-bit ULA operation codes (including the HOLD and PASSA_B codes)
//   - opcode / funct field constants of the decoded instruction
//   - sequencer FSM state encoding
//   - operand-B source select encoding and the helper that builds operand B
// ---------------------------------------------------------------------------
package ula_pkg;

   localparam int DATA_W = 32;
   localparam int CODE_W = 5;

   // ULA operation codes
   localparam logic [CODE_W-1:0] ULA_ADD     = 5'd0;
   localparam logic [CODE_W-1:0] ULA_SUB     = 5'd1;
   localparam logic [CODE_W-1:0] ULA_MULT    = 5'd2;
   localparam logic [CODE_W-1:0] ULA_DIV     = 5'd3;
   localparam logic [CODE_W-1:0] ULA_AND     = 5'd4;
   localparam logic [CODE_W-1:0] ULA_OR      = 5'd5;
   localparam logic [CODE_W-1:0] ULA_NAND    = 5'd6;
   localparam logic [CODE_W-1:0] ULA_NOR     = 5'd7;
   localparam logic [CODE_W-1:0] ULA_BEQ     = 5'd8;
   localparam logic [CODE_W-1:0] ULA_BNE     = 5'd9;
   localparam logic [CODE_W-1:0] ULA_BGT     = 5'd10;
   localparam logic [CODE_W-1:0] ULA_BLT     = 5'd11;
   localparam logic [CODE_W-1:0] ULA_SLT     = 5'd12;
   localparam logic [CODE_W-1:0] ULA_SLE     = 5'd13;
   localparam logic [CODE_W-1:0] ULA_SGE     = 5'd14;
   localparam logic [CODE_W-1:0] ULA_HOLD    = 5'd15;
   localparam logic [CODE_W-1:0] ULA_PASSA_B = 5'd31;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGT   = 6'h06;
   localparam logic [5:0] OP_BLT   = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   // R-type funct values
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NAND = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLE  = 6'h2B;
   localparam logic [5:0] FN_SGE  = 6'h2C;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      EXECUTA = 2'd1,
      CAPTURA = 2'd2,
      PRONTO  = 2'd3
   } estado_t;

   typedef enum logic [1:0] {
      SEL_B_REG  = 2'd0,
      SEL_B_SEXT = 2'd1,
      SEL_B_ZEXT = 2'd2,
      SEL_B_LUI  = 2'd3
   } sel_b_t;

   function automatic logic [DATA_W-1:0] monta_b(input sel_b_t      sel,
                                                 input logic [31:0] reg_b,
                                                 input logic [15:0] imm);
      logic [DATA_W-1:0] b;
      b = reg_b;
      case (sel)
         SEL_B_REG:  b = reg_b;
         SEL_B_SEXT: b = {{16{imm[15]}}, imm};
         SEL_B_ZEXT: b = {16'h0000, imm};
         SEL_B_LUI:  b = {imm, 16'h0000};
         default:    b = reg_b;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sequenciador_ula_decodifica.sv
// ---------------------------------------------------------------------------
// decodifica_ula
// Combinational opcode/funct decoder for the ULA sequencer.
// Ports:
//   opcode_i    [5:0]  instruction opcode
//   funct_i     [5:0]  R-type function field
//   codigo_o    [4:0]  ULA operation code (HOLD when not legal)
//   sel_b_o     [1:0]  operand-B source select
//   legal_o            opcode/funct pair is a supported instruction
//   eh_desvio_o        instruction is a branch (ULA zero becomes desvio)
// ---------------------------------------------------------------------------
module decodifica_ula
   import ula_pkg::*;
(
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   output logic [CODE_W-1:0] codigo_o,
   output sel_b_t            sel_b_o,
   output logic              legal_o,
   output logic              eh_desvio_o
);

   always_comb begin
      codigo_o    = ULA_HOLD;
      sel_b_o     = SEL_B_REG;
      legal_o     = 1'b0;
      eh_desvio_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            legal_o = 1'b1;
            case (funct_i)
               FN_ADD:  codigo_o = ULA_ADD;
               FN_SUB:  codigo_o = ULA_SUB;
               FN_MULT: codigo_o = ULA_MULT;
               FN_DIV:  codigo_o = ULA_DIV;
               FN_AND:  codigo_o = ULA_AND;
               FN_OR:   codigo_o = ULA_OR;
               FN_NAND: codigo_o = ULA_NAND;
               FN_NOR:  codigo_o = ULA_NOR;
               FN_SLT:  codigo_o = ULA_SLT;
               FN_SLE:  codigo_o = ULA_SLE;
               FN_SGE:  codigo_o = ULA_SGE;
               default: begin
                  codigo_o = ULA_HOLD;
                  legal_o  = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            codigo_o = ULA_ADD;
            sel_b_o  = SEL_B_SEXT;
            legal_o  = 1'b1;
         end
         OP_ANDI: begin
            codigo_o = ULA_AND;
            sel_b_o  = SEL_B_ZEXT;
            legal_o  = 1'b1;
         end
         OP_ORI: begin
            codigo_o = ULA_OR;
            sel_b_o  = SEL_B_ZEXT;
            legal_o  = 1'b1;
         end
         OP_LUI: begin
            codigo_o = ULA_PASSA_B;
            sel_b_o  = SEL_B_LUI;
            legal_o  = 1'b1;
         end
         OP_BEQ: begin
            codigo_o    = ULA_BEQ;
            legal_o     = 1'b1;
            eh_desvio_o = 1'b1;
         end
         OP_BNE: begin
            codigo_o    = ULA_BNE;
            legal_o     = 1'b1;
            eh_desvio_o = 1'b1;
         end
         OP_BGT: begin
            codigo_o    = ULA_BGT;
            legal_o     = 1'b1;
            eh_desvio_o = 1'b1;
         end
         OP_BLT: begin
            codigo_o    = ULA_BLT;
            legal_o     = 1'b1;
            eh_desvio_o = 1'b1;
         end
         default: begin
            codigo_o = ULA_HOLD;
            legal_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sequenciador_ula.sv
// ---------------------------------------------------------------------------
// sequenciador_ula
// Issue-side controller for the ULA. Accepts one decoded instruction over a
// valid/ready handshake, issues it to the ULA for exactly one cycle, captures
// the ULA's registered result one cycle later, and presents result plus
// branch/overflow/error flags over a second valid/ready handshake.
//
// State | meaning
// ------+---------------------------------------------------------------
// OCIOSO  | idle, in_ready=1, waiting for a request
// EXECUTA | ULA code driven; ULA registers its result at the end of it
// CAPTURA | ULA outputs valid, captured into the result registers
// PRONTO  | out_valid=1, results held until out_ready
//
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready, opcode, funct, op_a, op_b, imm   request side
//   ula_controle, ula_a, ula_b                         drive to ULA
//   ula_saida, ula_zero, ula_overflow                  registered ULA outputs
//   out_valid/out_ready, resultado, desvio, overflow, erro   result side
// ---------------------------------------------------------------------------
module sequenciador_ula
   import ula_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [15:0]       imm,
   output logic [CODE_W-1:0] ula_controle,
   output logic [DATA_W-1:0] ula_a,
   output logic [DATA_W-1:0] ula_b,
   input  logic [DATA_W-1:0] ula_saida,
   input  logic              ula_zero,
   input  logic              ula_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] resultado,
   output logic              desvio,
   output logic              overflow,
   output logic              erro
);

   estado_t           estado_q;
   logic [CODE_W-1:0] ula_controle_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              eh_desvio_q;
   logic [DATA_W-1:0] resultado_q;
   logic              desvio_q;
   logic              overflow_q;
   logic              erro_q;

   logic [CODE_W-1:0] codigo_d;
   sel_b_t            sel_b_d;
   logic              legal_d;
   logic              eh_desvio_d;
   logic [DATA_W-1:0] b_d;
   logic              emite_d;

   decodifica_ula u_decodifica (
      .opcode_i    (opcode),
      .funct_i     (funct),
      .codigo_o    (codigo_d),
      .sel_b_o     (sel_b_d),
      .legal_o     (legal_d),
      .eh_desvio_o (eh_desvio_d)
   );

   assign b_d = monta_b(sel_b_d, op_b, imm);

   // Divide by zero is rejected here rather than in the ULA so the ULA is
   // never issued an operation with an undefined result.
   assign emite_d = legal_d && !((codigo_d == ULA_DIV) && (op_b == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q       <= OCIOSO;
         ula_controle_q <= ULA_HOLD;
         a_q            <= '0;
         b_q            <= '0;
         eh_desvio_q    <= 1'b0;
         resultado_q    <= '0;
         desvio_q       <= 1'b0;
         overflow_q     <= 1'b0;
         erro_q         <= 1'b0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (in_valid) begin
                  a_q         <= op_a;
                  b_q         <= b_d;
                  eh_desvio_q <= eh_desvio_d;
                  if (emite_d) begin
                     ula_controle_q <= codigo_d;
                     estado_q       <= EXECUTA;
                  end else begin
                     resultado_q <= '0;
                     desvio_q    <= 1'b0;
                     overflow_q  <= 1'b0;
                     erro_q      <= 1'b1;
                     estado_q    <= PRONTO;
                  end
               end
            end
            EXECUTA: begin
               // The ULA latches on this edge; the code must drop back to
               // HOLD so its registered outputs stay put until captured.
               ula_controle_q <= ULA_HOLD;
               estado_q       <= CAPTURA;
            end
            CAPTURA: begin
               resultado_q <= ula_saida;
               overflow_q  <= ula_overflow;
               desvio_q    <= eh_desvio_q & ula_zero;
               erro_q      <= 1'b0;
               estado_q    <= PRONTO;
            end
            PRONTO: begin
               if (out_ready) begin
                  estado_q <= OCIOSO;
               end
            end
            default: begin
               ula_controle_q <= ULA_HOLD;
               estado_q       <= OCIOSO;
            end
         endcase
      end
   end

   assign in_ready     = (estado_q == OCIOSO);
   assign out_valid    = (estado_q == PRONTO);
   assign ula_controle = ula_controle_q;
   assign ula_a        = a_q;
   assign ula_b        = b_q;
   assign resultado    = resultado_q;
   assign desvio       = desvio_q;
   assign overflow     = overflow_q;
   assign erro         = erro_q;

endmodule

// File: tb/tb_sequenciador_ula.sv
module tb_sequenciador_ula;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [15:0] imm;
   logic [4:0]  ula_controle;
   logic [31:0] ula_a;
   logic [31:0] ula_b;
   logic [31:0] ula_saida;
   logic        ula_zero;
   logic        ula_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] resultado;
   logic        desvio;
   logic        overflow;
   logic        erro;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sequenciador_ula dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .funct        (funct),
      .op_a         (op_a),
      .op_b         (op_b),
      .imm          (imm),
      .ula_controle (ula_controle),
      .ula_a        (ula_a),
      .ula_b        (ula_b),
      .ula_saida    (ula_saida),
      .ula_zero     (ula_zero),
      .ula_overflow (ula_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .resultado    (resultado),
      .desvio       (desvio),
      .overflow     (overflow),
      .erro         (erro)
   );

   // Behavioural ULA: {overflow, zero, saida} for a code and operands.
   function automatic logic [33:0] ula_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        s;
      logic               z;
      logic               o;
      logic signed [63:0] p;
      s = 32'h0;
      o = 1'b0;
      p = 64'sh0;
      case (c)
         5'd0:  s = a + b;
         5'd1:  s = a - b;
         5'd2: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            s = p[31:0];
            o = (p[63:32] != {32{s[31]}});
         end
         5'd3:  s = (b == 0) ? 32'h0 : $signed(a) / $signed(b);
         5'd4:  s = a & b;
         5'd5:  s = a | b;
         5'd6:  s = ~(a & b);
         5'd7:  s = ~(a | b);
         5'd8, 5'd9, 5'd10, 5'd11: s = a - b;
         5'd12: s = {31'h0, $signed(a) <  $signed(b)};
         5'd13: s = {31'h0, $signed(a) <= $signed(b)};
         5'd14: s = {31'h0, $signed(a) >= $signed(b)};
         5'd31: s = b;
         default: s = 32'h0;
      endcase
      case (c)
         5'd8:    z = (a == b);
         5'd9:    z = (a != b);
         5'd10:   z = ($signed(a) > $signed(b));
         5'd11:   z = ($signed(a) < $signed(b));
         default: z = (s == 32'h0);
      endcase
      return {o, z, s};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         {ula_overflow, ula_zero, ula_saida} <= 34'h0;
      end else if (ula_controle != 5'd15) begin
         {ula_overflow, ula_zero, ula_saida} <= ula_fn(ula_controle, ula_a, ula_b);
      end
   end

   // Instruction table: opcode, funct (R-type only), ULA code, B source
   // (0 reg, 1 sign-ext, 2 zero-ext, 3 upper), is-branch.
   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] code;
      logic [1:0] bsrc;
      logic       br;
   } instr_t;

   instr_t tabela [19];
   initial begin
      tabela[0]  = '{6'h00, 6'h20, 5'd0,  2'd0, 1'b0};
      tabela[1]  = '{6'h00, 6'h22, 5'd1,  2'd0, 1'b0};
      tabela[2]  = '{6'h00, 6'h18, 5'd2,  2'd0, 1'b0};
      tabela[3]  = '{6'h00, 6'h1A, 5'd3,  2'd0, 1'b0};
      tabela[4]  = '{6'h00, 6'h24, 5'd4,  2'd0, 1'b0};
      tabela[5]  = '{6'h00, 6'h25, 5'd5,  2'd0, 1'b0};
      tabela[6]  = '{6'h00, 6'h26, 5'd6,  2'd0, 1'b0};
      tabela[7]  = '{6'h00, 6'h27, 5'd7,  2'd0, 1'b0};
      tabela[8]  = '{6'h00, 6'h2A, 5'd12, 2'd0, 1'b0};
      tabela[9]  = '{6'h00, 6'h2B, 5'd13, 2'd0, 1'b0};
      tabela[10] = '{6'h00, 6'h2C, 5'd14, 2'd0, 1'b0};
      tabela[11] = '{6'h08, 6'h00, 5'd0,  2'd1, 1'b0};
      tabela[12] = '{6'h0C, 6'h00, 5'd4,  2'd2, 1'b0};
      tabela[13] = '{6'h0D, 6'h00, 5'd5,  2'd2, 1'b0};
      tabela[14] = '{6'h04, 6'h00, 5'd8,  2'd0, 1'b1};
      tabela[15] = '{6'h05, 6'h00, 5'd9,  2'd0, 1'b1};
      tabela[16] = '{6'h06, 6'h00, 5'd10, 2'd0, 1'b1};
      tabela[17] = '{6'h07, 6'h00, 5'd11, 2'd0, 1'b1};
      tabela[18] = '{6'h0F, 6'h00, 5'd31, 2'd3, 1'b0};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Issue one request and check the whole transaction against the table
   // and the behavioural ULA. hold = cycles out_ready stays low in PRONTO.
   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [15:0] im, input int hold);
      bit          found;
      instr_t      e;
      logic [31:0] beff;
      logic [33:0] r;
      bit          issue;
      logic [31:0] exp_res;
      logic        exp_des;
      logic        exp_ovf;
      logic        exp_err;
      int          guard;
      int          k;
      int          pulses;
      logic [4:0]  seen;

      found = 0;
      e     = '0;
      for (int i = 0; i < 19; i++) begin
         if (!found && tabela[i].op == opc && (opc != 6'h00 || tabela[i].fn == fn)) begin
            found = 1;
            e     = tabela[i];
         end
      end
      case (e.bsrc)
         2'd1:    beff = {{16{im[15]}}, im};
         2'd2:    beff = {16'h0, im};
         2'd3:    beff = {im, 16'h0};
         default: beff = b;
      endcase
      issue = found && !(e.code == 5'd3 && b == 0);
      r     = ula_fn(e.code, a, beff);
      if (issue) begin
         exp_res = r[31:0];
         exp_des = e.br & r[32];
         exp_ovf = r[33];
         exp_err = 1'b0;
      end else begin
         exp_res = 32'h0;
         exp_des = 1'b0;
         exp_ovf = 1'b0;
         exp_err = 1'b1;
      end

      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", {31'h0, in_ready}, 32'h1);

      in_valid  = 1'b1;
      opcode    = opc;
      funct     = fn;
      op_a      = a;
      op_b      = b;
      imm       = im;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = 6'($urandom);
      funct     = 6'($urandom);
      op_a      = $urandom;
      op_b      = $urandom;
      imm       = 16'($urandom);

      k      = 0;
      pulses = 0;
      seen   = 5'd15;
      forever begin
         @(negedge clk);
         if (ula_controle != 5'd15) begin
            pulses++;
            seen = ula_controle;
         end
         if (k == 0 && issue) begin
            check("ula_a", ula_a, a);
            check("ula_b", ula_b, beff);
         end
         if (out_valid || k >= 10) break;
         k++;
      end
      check("latency", k, issue ? 2 : 0);
      check("ctl_pulses", pulses, issue ? 1 : 0);
      if (issue) check("ctl_code", {27'h0, seen}, {27'h0, e.code});
      check("resultado", resultado, exp_res);
      check("desvio", {31'h0, desvio}, {31'h0, exp_des});
      check("overflow", {31'h0, overflow}, {31'h0, exp_ovf});
      check("erro", {31'h0, erro}, {31'h0, exp_err});

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", {31'h0, out_valid}, 32'h1);
         check("hold_ready", {31'h0, in_ready}, 32'h0);
         check("hold_res", resultado, exp_res);
         check("hold_flags", {29'h0, desvio, overflow, erro}, {29'h0, exp_des, exp_ovf, exp_err});
         check("hold_ctl", {27'h0, ula_controle}, 32'd15);
      end

      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check("post_in_ready", {31'h0, in_ready}, 32'h1);
      check("post_out_valid", {31'h0, out_valid}, 32'h0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(0, 20);
         1:       return 32'hFFFF_FFF0 + $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = 6'h0;
      funct     = 6'h0;
      op_a      = 32'h0;
      op_b      = 32'h0;
      imm       = 16'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_in_ready", {31'h0, in_ready}, 32'h1);
         check("rst_out_valid", {31'h0, out_valid}, 32'h0);
         check("rst_ctl", {27'h0, ula_controle}, 32'd15);
         check("rst_outs", resultado | {29'h0, desvio, overflow, erro} | ula_a | ula_b, 32'h0);
      end

      run_instr(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0);
      run_instr(6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFF, 0);
      run_instr(6'h0F, 6'h00, 32'd99, 32'd1, 16'h1234, 0);
      run_instr(6'h04, 6'h00, 32'd3, 32'd3, 16'h0, 0);
      run_instr(6'h05, 6'h00, 32'd3, 32'd3, 16'h0, 0);
      run_instr(6'h00, 6'h2A, 32'd2, 32'd9, 16'h0, 0);
      run_instr(6'h00, 6'h22, 32'd4, 32'd4, 16'h0, 1);
      run_instr(6'h00, 6'h1A, 32'd8, 32'd0, 16'h0, 1);
      run_instr(6'h3F, 6'h20, 32'd1, 32'd2, 16'h0, 0);
      run_instr(6'h00, 6'h18, 32'h0001_0000, 32'h0001_0000, 16'h0, 0);
      run_instr(6'h0C, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h8001, 5);

      // Reset while in EXECUTA: result must never appear.
      in_valid = 1'b1;
      opcode   = 6'h00;
      funct    = 6'h20;
      op_a     = 32'd1;
      op_b     = 32'd2;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_mid_ctl", {27'h0, ula_controle}, 32'd15);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
      end

      for (int n = 0; n < 80; n++) begin
         logic [5:0]  ropc;
         logic [5:0]  rfn;
         logic [31:0] ra;
         logic [31:0] rb;
         int          sel;
         instr_t      t;
         sel = $urandom_range(0, 24);
         t   = tabela[sel % 19];
         ropc = t.op;
         rfn  = (t.op == 6'h00) ? t.fn : 6'($urandom);
         ra   = rnd_operand();
         rb   = ($urandom_range(0, 3) == 0) ? ra : rnd_operand();
         if (sel == 19) begin
            ropc = 6'h00;
            rfn  = 6'h1A;
            rb   = 32'h0;
         end else if (sel == 20) begin
            ropc = 6'h00;
            rfn  = 6'h21;
         end else if (sel == 21) begin
            ropc = 6'h3F;
         end
         run_instr(ropc, rfn, ra, rb, 16'($urandom), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
